prog_loader: RTL and testbench

//  Boot-time program loader, upstream of the CPU memory. Receives a framed byte stream
//  (length, payload, checksum) on a valid/ready byte interface and writes the payload

---
 rtl/edulent_pkg.sv | 16 +
 rtl/prog_loader.sv | 190 +++++++++++++++++++
 tb/tb_prog_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edulent_pkg.sv
// Shared types and constants for the boot-time program loader.
//   loader_state_t  : loader FSM states
//   LEN_ZERO_IS_256 : payload length represented by a LEN byte of zero
package edulent_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } loader_state_t;

  localparam logic [8:0] LEN_ZERO_IS_256 = 9'd256;

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader. Accepts a framed byte stream (LEN, LEN payload
// bytes, XOR checksum) on a valid/ready interface, writes the payload into
// program memory starting at BASE_ADDR and keeps the CPU in reset until a
// frame has been verified.
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_rx_data/valid      stream byte and its valid
//   o_rx_ready           loader accepts a byte this cycle
//   i_load_req           level request, in RUN, to go back to load mode
//   o_mem_addr/data_write/write_enable  registered memory write port
//   o_mem_sel            1 while the loader owns the memory port
//   o_cpu_rstn           CPU reset, active low
//   o_done               frame verified, CPU running
//   o_err                sticky checksum/timeout error, cleared by next LEN
module prog_loader
  import edulent_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int BASE_ADDR      = 0,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  input  logic              i_load_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data_write,
  output logic              o_mem_write_enable,
  output logic              o_mem_sel,
  output logic              o_cpu_rstn,
  output logic              o_done,
  output logic              o_err
);

  localparam int TMO_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = (HOLD_CYCLES <= 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  =
    (TIMEOUT_CYCLES == 0) ? '0 : TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  loader_state_t     state_q, state_d;
  logic [8:0]        len_q, len_d;
  logic [8:0]        idx_q, idx_d;
  logic [DATA_W-1:0] xor_q, xor_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              run_q, run_d;

  logic acc;
  logic tmo_hit;

  assign acc = i_rx_valid & ready_q;
  // The idle counter expires on the cycle it would reach TIMEOUT_CYCLES;
  // an accepted byte in that cycle takes priority because it is checked first.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = LOAD;
          len_d   = (i_rx_data == '0) ? LEN_ZERO_IS_256 : 9'(i_rx_data);
          idx_d   = '0;
          xor_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
        end
      end

      LOAD: begin
        if (acc) begin
          we_d   = 1'b1;
          addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
          data_d = i_rx_data;
          idx_d  = idx_q + 9'd1;
          xor_d  = xor_q ^ i_rx_data;
          tmo_d  = '0;
          if (idx_q + 9'd1 == len_q) begin
            state_d = CHECK;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      CHECK: begin
        if (acc) begin
          tmo_d = '0;
          if (i_rx_data == xor_q) begin
            state_d = HOLD;
            hold_d  = '0;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      RUN: begin
        if (i_load_req) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so the CPU reset line is
    // glitch-free and ready stays low during the reset cycle itself.
    ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == CHECK);
    run_d   = (state_d == RUN);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      xor_q   <= '0;
      tmo_q   <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      run_q   <= run_d;
    end
  end

  assign o_rx_ready         = ready_q;
  assign o_mem_addr         = addr_q;
  assign o_mem_data_write   = data_q;
  assign o_mem_write_enable = we_q;
  assign o_mem_sel          = ~run_q;
  assign o_cpu_rstn         = run_q;
  assign o_done             = run_q;
  assign o_err              = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one instance with default parameters and
// one with BASE_ADDR=0xFE, TIMEOUT_CYCLES=8.
module tb_prog_loader;

  logic       clk;
  logic       rstn0, rstn1;
  logic [7:0] dat0, dat1;
  logic       vld0, vld1;
  logic       rdy0, rdy1;
  logic       req0, req1;
  logic [7:0] addr0, addr1;
  logic [7:0] wd0, wd1;
  logic       we0, we1;
  logic       sel0, sel1;
  logic       crst0, crst1;
  logic       done0, done1;
  logic       err0, err1;

  int total = 0;
  int bad   = 0;

  logic [7:0] la0[$], ld0[$], la1[$], ld1[$];

  prog_loader u_dut0 (
    .i_clk(clk), .i_rstn(rstn0), .i_rx_data(dat0), .i_rx_valid(vld0),
    .o_rx_ready(rdy0), .i_load_req(req0), .o_mem_addr(addr0),
    .o_mem_data_write(wd0), .o_mem_write_enable(we0), .o_mem_sel(sel0),
    .o_cpu_rstn(crst0), .o_done(done0), .o_err(err0)
  );

  prog_loader #(.BASE_ADDR(8'hFE), .TIMEOUT_CYCLES(8)) u_dut1 (
    .i_clk(clk), .i_rstn(rstn1), .i_rx_data(dat1), .i_rx_valid(vld1),
    .o_rx_ready(rdy1), .i_load_req(req1), .o_mem_addr(addr1),
    .o_mem_data_write(wd1), .o_mem_write_enable(we1), .o_mem_sel(sel1),
    .o_cpu_rstn(crst1), .o_done(done1), .o_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log, sampled on the falling edge so each one-cycle strobe is seen once.
  always @(negedge clk) begin
    if (we0 === 1'b1) begin la0.push_back(addr0); ld0.push_back(wd0); end
    if (we1 === 1'b1) begin la1.push_back(addr1); ld1.push_back(wd1); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send0(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    vld0 = 1'b1; dat0 = b;
    while (rdy0 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (rdy0 !== 1'b1) chk("send0_ready_wait", 32'(rdy0), 32'd1);
    @(posedge clk); #1;
    vld0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    vld1 = 1'b1; dat1 = b;
    while (rdy1 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (rdy1 !== 1'b1) chk("send1_ready_wait", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    vld1 = 1'b0;
  endtask

  task automatic loadreq0();
    @(negedge clk); req0 = 1'b1;
    @(posedge clk); #1;
    chk("req_cpu_rstn", 32'(crst0), 32'd0);
    chk("req_done", 32'(done0), 32'd0);
    chk("req_sel", 32'(sel0), 32'd1);
    req0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_a [4];
    int n_before;
    int errs;
    rstn0 = 1'b0; rstn1 = 1'b0;
    vld0 = 1'b0; vld1 = 1'b0; dat0 = '0; dat1 = '0;
    req0 = 1'b0; req1 = 1'b0;

    // Reset values
    #2;
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_cpu_rstn", 32'(crst0), 32'd0);
    chk("rst_sel", 32'(sel0), 32'd1);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_data", 32'(wd0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    #20;
    rstn0 = 1'b1; rstn1 = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready0", 32'(rdy0), 32'd1);
    chk("rel_ready1", 32'(rdy1), 32'd1);
    chk("rel_cpu_rstn", 32'(crst0), 32'd0);

    // Good frame LEN=3 11 22 33 CHK=00, write one cycle after each payload byte
    la0.delete(); ld0.delete();
    send0(8'd3);
    chk("A_len_no_write", 32'(we0), 32'd0);
    send0(8'h11);
    chk("A_we0", 32'(we0), 32'd1);
    chk("A_addr0", 32'(addr0), 32'h00);
    chk("A_data0", 32'(wd0), 32'h11);
    send0(8'h22);
    chk("A_we1", 32'(we0), 32'd1);
    chk("A_addr1", 32'(addr0), 32'h01);
    send0(8'h33);
    chk("A_addr2", 32'(addr0), 32'h02);
    chk("A_data2", 32'(wd0), 32'h33);
    send0(8'h00);
    chk("A_chk_no_write", 32'(we0), 32'd0);
    chk("A_hold_ready", 32'(rdy0), 32'd0);
    chk("A_hold_cpu", 32'(crst0), 32'd0);
    @(posedge clk); #1;
    chk("A_hold1_cpu", 32'(crst0), 32'd0);
    @(posedge clk); #1;
    chk("A_run_cpu", 32'(crst0), 32'd1);
    chk("A_run_done", 32'(done0), 32'd1);
    chk("A_run_sel", 32'(sel0), 32'd0);
    chk("A_run_ready", 32'(rdy0), 32'd0);
    chk("A_nwrites", la0.size(), 3);
    chk("A_log_d1", 32'(ld0.size() > 1 ? ld0[1] : 8'hXX), 32'h22);

    // Stream ignored in RUN
    n_before = la0.size();
    @(negedge clk); vld0 = 1'b1; dat0 = 8'h55;
    repeat (3) @(posedge clk);
    #1; vld0 = 1'b0;
    chk("run_ignore_writes", la0.size(), n_before);
    chk("run_ignore_done", 32'(done0), 32'd1);

    // Back to load mode, bad checksum
    loadreq0();
    chk("req_ready", 32'(rdy0), 32'd1);
    send0(8'd3); send0(8'h11); send0(8'h22); send0(8'h33); send0(8'h01);
    chk("B_err", 32'(err0), 32'd1);
    chk("B_ready_idle", 32'(rdy0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("B_no_release", 32'(crst0), 32'd0);
    chk("B_err_sticky", 32'(err0), 32'd1);

    // Next good frame clears the error on LEN
    send0(8'd1);
    chk("C_err_clear", 32'(err0), 32'd0);
    send0(8'hA5); send0(8'hA5);
    repeat (2) @(posedge clk);
    #1;
    chk("C_done", 32'(done0), 32'd1);

    // LEN=0 means 256 bytes; XOR of 0..255 is 0
    loadreq0();
    la0.delete(); ld0.delete();
    send0(8'h00);
    for (int i = 0; i < 256; i++) send0(8'(i));
    send0(8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("D_nwrites", la0.size(), 256);
    errs = 0;
    for (int i = 0; i < la0.size(); i++)
      if (la0[i] !== 8'(i) || ld0[i] !== 8'(i)) errs++;
    chk("D_addr_data", errs, 0);
    chk("D_done", 32'(done0), 32'd1);
    chk("D_err", 32'(err0), 32'd0);

    // Async reset in the middle of LOAD
    loadreq0();
    send0(8'd5); send0(8'hAA);
    chk("E_we_before_rst", 32'(we0), 32'd1);
    #2 rstn0 = 1'b0;
    #1;
    chk("E_rst_we", 32'(we0), 32'd0);
    chk("E_rst_addr", 32'(addr0), 32'd0);
    chk("E_rst_data", 32'(wd0), 32'd0);
    chk("E_rst_ready", 32'(rdy0), 32'd0);
    chk("E_rst_sel", 32'(sel0), 32'd1);
    @(negedge clk); rstn0 = 1'b1;
    @(posedge clk); #1;
    chk("E_rel_ready", 32'(rdy0), 32'd1);

    // Address wrap from BASE_ADDR=0xFE; CHK = 1^2^3^4 = 4
    la1.delete(); ld1.delete();
    send1(8'd4); send1(8'd1); send1(8'd2); send1(8'd3); send1(8'd4); send1(8'd4);
    repeat (2) @(posedge clk);
    #1;
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    chk("F_nwrites", la1.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("F_addr%0d", i), 32'(la1.size() > i ? la1[i] : 8'hXX), 32'(exp_a[i]));
    chk("F_done", 32'(done1), 32'd1);

    // Stall 7 idle cycles mid-payload: no timeout
    @(negedge clk); req1 = 1'b1;
    @(negedge clk); req1 = 1'b0;
    send1(8'd3); send1(8'h10);
    repeat (7) @(posedge clk);
    send1(8'h20);
    chk("G_stall7_err", 32'(err1), 32'd0);
    send1(8'h30); send1(8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("G_done", 32'(done1), 32'd1);
    chk("G_err_final", 32'(err1), 32'd0);

    // Stall 8 idle cycles mid-payload: timeout
    @(negedge clk); req1 = 1'b1;
    @(negedge clk); req1 = 1'b0;
    send1(8'd3); send1(8'h10);
    repeat (7) @(posedge clk);
    #1;
    chk("H_stall7_no_err", 32'(err1), 32'd0);
    @(posedge clk); #1;
    chk("H_stall8_err", 32'(err1), 32'd1);
    chk("H_idle_ready", 32'(rdy1), 32'd1);
    chk("H_cpu_held", 32'(crst1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
